// File: rtl/axi_slave_mem_responder_if.sv
// AXI3-style slave bus bundle (AW/W/B/AR/R channels) for the memory responder.
// Clock and reset are kept outside the bundle as plain module ports.
interface axi_slave_mem_responder_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]     S_AWID;
    logic [ADDR_W-1:0]   S_AWADDR;
    logic [3:0]          S_AWLEN;
    logic [1:0]          S_AWBURST;
    logic                S_AWVALID;
    logic                S_AWREADY;

    logic [DATA_W-1:0]   S_WDATA;
    logic [DATA_W/8-1:0] S_WSTRB;
    logic                S_WLAST;
    logic                S_WVALID;
    logic                S_WREADY;

    logic [ID_W-1:0]     S_BID;
    logic [1:0]          S_BRESP;
    logic                S_BVALID;
    logic                S_BREADY;

    logic [ID_W-1:0]     S_ARID;
    logic [ADDR_W-1:0]   S_ARADDR;
    logic [3:0]          S_ARLEN;
    logic [1:0]          S_ARBURST;
    logic                S_ARVALID;
    logic                S_ARREADY;

    logic [ID_W-1:0]     S_RID;
    logic [DATA_W-1:0]   S_RDATA;
    logic [1:0]          S_RRESP;
    logic                S_RLAST;
    logic                S_RVALID;
    logic                S_RREADY;

    modport slave (
        input  S_AWID, S_AWADDR, S_AWLEN, S_AWBURST, S_AWVALID,
        output S_AWREADY,
        input  S_WDATA, S_WSTRB, S_WLAST, S_WVALID,
        output S_WREADY,
        output S_BID, S_BRESP, S_BVALID,
        input  S_BREADY,
        input  S_ARID, S_ARADDR, S_ARLEN, S_ARBURST, S_ARVALID,
        output S_ARREADY,
        output S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID,
        input  S_RREADY
    );

    modport master (
        output S_AWID, S_AWADDR, S_AWLEN, S_AWBURST, S_AWVALID,
        input  S_AWREADY,
        output S_WDATA, S_WSTRB, S_WLAST, S_WVALID,
        input  S_WREADY,
        input  S_BID, S_BRESP, S_BVALID,
        output S_BREADY,
        output S_ARID, S_ARADDR, S_ARLEN, S_ARBURST, S_ARVALID,
        input  S_ARREADY,
        input  S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID,
        output S_RREADY
    );
endinterface

// File: rtl/axi_slave_mem_responder.sv
// AXI slave memory responder: one outstanding write and one outstanding read,
// independent FSMs, byte-lane memory with registered read data.
module axi_slave_mem_responder #(
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    axi_slave_mem_responder_if.slave  s_axi
);
    localparam int NBYTES    = DATA_W / 8;
    localparam int BYTE_BITS = $clog2(NBYTES);
    localparam int IDX_BITS  = $clog2(MEM_DEPTH);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // WRAP keeps the upper address bits and lets the low bits roll over
    // inside the (LEN+1)*NBYTES window.
    function automatic logic [ADDR_W-1:0] f_next_addr(
        input logic [ADDR_W-1:0] addr,
        input logic [3:0]        len,
        input logic [1:0]        burst
    );
        logic [ADDR_W-1:0] incr;
        logic [ADDR_W-1:0] mask;
        incr = addr + ADDR_W'(NBYTES);
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << BYTE_BITS) - ADDR_W'(1);
        case (burst)
            BURST_FIXED: return addr;
            BURST_WRAP:  return (addr & ~mask) | (incr & mask);
            default:     return incr;
        endcase
    endfunction

    // ---------------- write side ----------------
    w_state_t           r_wstate;
    logic               r_awready;
    logic               r_wready;
    logic               r_bvalid;
    logic [ID_W-1:0]    r_bid;
    logic [1:0]         r_bresp;
    logic [ADDR_W-1:0]  r_aw_addr;
    logic [3:0]         r_aw_len;
    logic [1:0]         r_aw_burst;
    logic [3:0]         r_wbeat;
    logic               r_werr;

    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_w_last_beat;
    logic                w_w_oob;
    logic                w_w_beat_err;
    logic                w_mem_we;
    logic [IDX_BITS-1:0] w_w_idx;

    assign w_aw_hs       = s_axi.S_AWVALID & r_awready;
    assign w_w_hs        = s_axi.S_WVALID & r_wready;
    assign w_w_last_beat = (r_wbeat == r_aw_len);
    assign w_w_idx       = r_aw_addr[BYTE_BITS +: IDX_BITS];
    assign w_w_oob       = |(r_aw_addr >> (BYTE_BITS + IDX_BITS));
    assign w_w_beat_err  = w_w_oob | (s_axi.S_WLAST != w_w_last_beat);
    assign w_mem_we      = w_w_hs & ~w_w_oob;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wstate   <= W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bid      <= '0;
            r_bresp    <= RESP_OKAY;
            r_aw_addr  <= '0;
            r_aw_len   <= '0;
            r_aw_burst <= '0;
            r_wbeat    <= '0;
            r_werr     <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_bid      <= s_axi.S_AWID;
                        r_aw_addr  <= s_axi.S_AWADDR;
                        r_aw_len   <= s_axi.S_AWLEN;
                        r_aw_burst <= s_axi.S_AWBURST;
                        r_wbeat    <= '0;
                        r_werr     <= (s_axi.S_AWBURST == BURST_RSVD);
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b1;
                        r_wstate   <= W_DATA;
                    end else begin
                        r_awready  <= 1'b1;
                    end
                end
                W_DATA: begin
                    // Beat count alone ends the burst; WLAST only grades the response.
                    if (w_w_hs) begin
                        if (w_w_last_beat) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr | w_w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            r_wstate <= W_RESP;
                        end else begin
                            r_wbeat   <= r_wbeat + 4'd1;
                            r_aw_addr <= f_next_addr(r_aw_addr, r_aw_len, r_aw_burst);
                            r_werr    <= r_werr | w_w_beat_err;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.S_BREADY) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // ---------------- read side ----------------
    r_state_t           r_rstate;
    logic               r_arready;
    logic               r_rvalid;
    logic               r_rlast;
    logic [ID_W-1:0]    r_rid;
    logic [DATA_W-1:0]  r_rdata;
    logic [1:0]         r_rresp;
    logic [ADDR_W-1:0]  r_ar_addr;
    logic [3:0]         r_ar_len;
    logic [1:0]         r_ar_burst;
    logic [3:0]         r_rbeat;

    logic                w_ar_hs;
    logic [ADDR_W-1:0]   w_r_rd_addr;
    logic [IDX_BITS-1:0] w_r_rd_idx;
    logic                w_r_rd_oob;
    logic                w_r_rsvd;
    logic [DATA_W-1:0]   w_rd_word;
    logic [DATA_W-1:0]   w_r_beat_data;
    logic [1:0]          w_r_beat_resp;

    // Address of the beat loaded into RDATA at the coming edge: the AR address
    // when idle, otherwise the successor of the beat now on the bus.
    assign w_ar_hs       = s_axi.S_ARVALID & r_arready;
    assign w_r_rd_addr   = (r_rstate == R_IDLE) ? s_axi.S_ARADDR
                                                : f_next_addr(r_ar_addr, r_ar_len, r_ar_burst);
    assign w_r_rd_idx    = w_r_rd_addr[BYTE_BITS +: IDX_BITS];
    assign w_r_rd_oob    = |(w_r_rd_addr >> (BYTE_BITS + IDX_BITS));
    assign w_r_rsvd      = (r_rstate == R_IDLE) ? (s_axi.S_ARBURST == BURST_RSVD)
                                                : (r_ar_burst == BURST_RSVD);
    assign w_r_beat_data = w_r_rd_oob ? '0 : w_rd_word;
    assign w_r_beat_resp = (w_r_rd_oob | w_r_rsvd) ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rstate   <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_rid      <= '0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_ar_addr  <= '0;
            r_ar_len   <= '0;
            r_ar_burst <= '0;
            r_rbeat    <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rid      <= s_axi.S_ARID;
                        r_ar_addr  <= s_axi.S_ARADDR;
                        r_ar_len   <= s_axi.S_ARLEN;
                        r_ar_burst <= s_axi.S_ARBURST;
                        r_rbeat    <= '0;
                        r_rdata    <= w_r_beat_data;
                        r_rresp    <= w_r_beat_resp;
                        r_rlast    <= (s_axi.S_ARLEN == 4'd0);
                        r_rvalid   <= 1'b1;
                        r_arready  <= 1'b0;
                        r_rstate   <= R_DATA;
                    end else begin
                        r_arready  <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi.S_RREADY) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_ar_addr <= w_r_rd_addr;
                            r_rbeat   <= r_rbeat + 4'd1;
                            r_rlast   <= ((r_rbeat + 4'd1) == r_ar_len);
                            r_rdata   <= w_r_beat_data;
                            r_rresp   <= w_r_beat_resp;
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // One byte-wide array per lane: strobed writes map onto byte-enable RAM,
    // and reading in the same edge as a write yields the old contents.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
            logic [7:0] r_lane [MEM_DEPTH];

            always_ff @(posedge ACLK) begin
                if (w_mem_we && s_axi.S_WSTRB[gi]) begin
                    r_lane[w_w_idx] <= s_axi.S_WDATA[gi*8 +: 8];
                end
            end

            assign w_rd_word[gi*8 +: 8] = r_lane[w_r_rd_idx];
        end
    endgenerate

    assign s_axi.S_AWREADY = r_awready;
    assign s_axi.S_WREADY  = r_wready;
    assign s_axi.S_BID     = r_bid;
    assign s_axi.S_BRESP   = r_bresp;
    assign s_axi.S_BVALID  = r_bvalid;
    assign s_axi.S_ARREADY = r_arready;
    assign s_axi.S_RID     = r_rid;
    assign s_axi.S_RDATA   = r_rdata;
    assign s_axi.S_RRESP   = r_rresp;
    assign s_axi.S_RLAST   = r_rlast;
    assign s_axi.S_RVALID  = r_rvalid;
endmodule

// File: tb/tb_axi_slave_mem_responder.sv
// Directed bench for axi_slave_mem_responder: stimulus pushes expected B/R
// responses into queues, a negedge monitor pops and compares them.
module tb_axi_slave_mem_responder;
    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;
    localparam logic [1:0] RSVD   = 2'b11;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_slave_mem_responder_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) bus();

    axi_slave_mem_responder #(
        .ID_W(4), .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(256)
    ) dut (
        .ACLK    (clk),
        .ARESETn (rst_n),
        .s_axi   (bus)
    );

    typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

    b_exp_t      b_q[$];
    r_exp_t      r_q[$];
    int          n_vec    = 0;
    int          n_err    = 0;
    int          r_hs_cnt = 0;
    logic [31:0] vd [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got no completion, expected it within the cycle budget", name);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        b_exp_t be;
        r_exp_t re;
        logic b_pv, b_pr, r_pv, r_pr;
        logic [3:0] b_pid;
        logic [1:0] b_presp;
        r_exp_t r_prev;
        b_pv = 1'b0; b_pr = 1'b0; r_pv = 1'b0; r_pr = 1'b0;
        b_pid = '0; b_presp = '0;
        r_prev = '{4'd0, 32'd0, 2'd0, 1'b0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                b_pv = 1'b0;
                r_pv = 1'b0;
            end else begin
                if (b_pv && !b_pr) begin
                    chk("b_hold_valid", {31'd0, bus.S_BVALID}, 32'd1);
                    chk("b_hold_id",    {28'd0, bus.S_BID},    {28'd0, b_pid});
                    chk("b_hold_resp",  {30'd0, bus.S_BRESP},  {30'd0, b_presp});
                end
                if (r_pv && !r_pr) begin
                    chk("r_hold_valid", {31'd0, bus.S_RVALID}, 32'd1);
                    chk("r_hold_id",    {28'd0, bus.S_RID},    {28'd0, r_prev.id});
                    chk("r_hold_data",  bus.S_RDATA,           r_prev.data);
                    chk("r_hold_last",  {31'd0, bus.S_RLAST},  {31'd0, r_prev.last});
                end
                if (bus.S_BVALID && bus.S_BREADY) begin
                    $display("B  id=%0d resp=%0d", bus.S_BID, bus.S_BRESP);
                    if (b_q.size() == 0) begin
                        timeout_fail("b_unexpected");
                    end else begin
                        be = b_q.pop_front();
                        chk("bid",   {28'd0, bus.S_BID},   {28'd0, be.id});
                        chk("bresp", {30'd0, bus.S_BRESP}, {30'd0, be.resp});
                    end
                end
                if (bus.S_RVALID && bus.S_RREADY) begin
                    $display("R  id=%0d data=0x%08h resp=%0d last=%0d",
                             bus.S_RID, bus.S_RDATA, bus.S_RRESP, bus.S_RLAST);
                    r_hs_cnt++;
                    if (r_q.size() == 0) begin
                        timeout_fail("r_unexpected");
                    end else begin
                        re = r_q.pop_front();
                        chk("rid",   {28'd0, bus.S_RID},   {28'd0, re.id});
                        chk("rdata", bus.S_RDATA,          re.data);
                        chk("rresp", {30'd0, bus.S_RRESP}, {30'd0, re.resp});
                        chk("rlast", {31'd0, bus.S_RLAST}, {31'd0, re.last});
                    end
                end
                b_pv = bus.S_BVALID; b_pr = bus.S_BREADY;
                b_pid = bus.S_BID;   b_presp = bus.S_BRESP;
                r_pv = bus.S_RVALID; r_pr = bus.S_RREADY;
                r_prev = '{bus.S_RID, bus.S_RDATA, bus.S_RRESP, bus.S_RLAST};
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [1:0] burst);
        int t = 0;
        bus.S_AWID = id; bus.S_AWADDR = addr; bus.S_AWLEN = len; bus.S_AWBURST = burst;
        bus.S_AWVALID = 1'b1;
        @(negedge clk);
        while (!bus.S_AWREADY && t < 50) begin @(negedge clk); t++; end
        if (!bus.S_AWREADY) timeout_fail("aw_timeout");
        @(posedge clk); #1;
        bus.S_AWVALID = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int t = 0;
        bus.S_WDATA = data; bus.S_WSTRB = strb; bus.S_WLAST = last;
        bus.S_WVALID = 1'b1;
        @(negedge clk);
        while (!bus.S_WREADY && t < 50) begin @(negedge clk); t++; end
        if (!bus.S_WREADY) timeout_fail("w_timeout");
        @(posedge clk); #1;
        bus.S_WVALID = 1'b0;
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [1:0] burst);
        int t = 0;
        bus.S_ARID = id; bus.S_ARADDR = addr; bus.S_ARLEN = len; bus.S_ARBURST = burst;
        bus.S_ARVALID = 1'b1;
        @(negedge clk);
        while (!bus.S_ARREADY && t < 50) begin @(negedge clk); t++; end
        if (!bus.S_ARREADY) timeout_fail("ar_timeout");
        @(posedge clk); #1;
        bus.S_ARVALID = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((b_q.size() != 0 || r_q.size() != 0) && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (b_q.size() != 0 || r_q.size() != 0) timeout_fail("drain_timeout");
        b_q.delete();
        r_q.delete();
    endtask

    // Beats carry vd[0..len]; after the last beat the B response must already be up.
    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr,
                               input logic [3:0] len, input logic [1:0] burst,
                               input logic [3:0] strb, input logic [15:0] last_mask,
                               input logic [1:0] exp_resp);
        b_q.push_back('{id, exp_resp});
        do_aw(id, addr, len, burst);
        for (int i = 0; i <= int'(len); i++) do_w(vd[i], strb, last_mask[i]);
        chk("bvalid_after_last_beat", {31'd0, bus.S_BVALID}, 32'd1);
        chk("wready_after_last_beat", {31'd0, bus.S_WREADY}, 32'd0);
    endtask

    task automatic push_r(input logic [3:0] id, input logic [3:0] len, input logic [15:0] err_mask);
        for (int i = 0; i <= int'(len); i++)
            r_q.push_back('{id, vd[i], err_mask[i] ? SLVERR : OKAY, (i == int'(len))});
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr,
                              input logic [3:0] len, input logic [1:0] burst,
                              input logic [15:0] err_mask);
        push_r(id, len, err_mask);
        do_ar(id, addr, len, burst);
        drain();
    endtask

    task automatic set_vd4(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d);
        vd[0] = a; vd[1] = b; vd[2] = c; vd[3] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected $finish before 200us");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int t;
        int target;
        bus.S_AWID = '0; bus.S_AWADDR = '0; bus.S_AWLEN = '0; bus.S_AWBURST = '0; bus.S_AWVALID = 1'b0;
        bus.S_WDATA = '0; bus.S_WSTRB = '0; bus.S_WLAST = 1'b0; bus.S_WVALID = 1'b0;
        bus.S_BREADY = 1'b1;
        bus.S_ARID = '0; bus.S_ARADDR = '0; bus.S_ARLEN = '0; bus.S_ARBURST = '0; bus.S_ARVALID = 1'b0;
        bus.S_RREADY = 1'b1;
        for (int i = 0; i < 16; i++) vd[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", {31'd0, bus.S_AWREADY}, 32'd0);
        chk("rst_arready", {31'd0, bus.S_ARREADY}, 32'd0);
        chk("rst_wready",  {31'd0, bus.S_WREADY},  32'd0);
        chk("rst_bvalid",  {31'd0, bus.S_BVALID},  32'd0);
        chk("rst_rvalid",  {31'd0, bus.S_RVALID},  32'd0);
        chk("rst_rlast",   {31'd0, bus.S_RLAST},   32'd0);
        chk("rst_rdata",   bus.S_RDATA,            32'd0);
        chk("rst_bresp",   {30'd0, bus.S_BRESP},   32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("awready_first_edge", {31'd0, bus.S_AWREADY}, 32'd1);
        chk("arready_first_edge", {31'd0, bus.S_ARREADY}, 32'd1);

        // INCR write/read at 0x10
        set_vd4(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        write_burst(4'h5, 32'h10, 4'd3, INCR, 4'hF, 16'h0008, OKAY); drain();
        read_burst(4'h6, 32'h10, 4'd3, INCR, 16'h0);

        // WRAP at 0x08: words 2,3,0,1
        set_vd4(32'hB0, 32'hB1, 32'hB2, 32'hB3);
        write_burst(4'h1, 32'h08, 4'd3, WRAP, 4'hF, 16'h0008, OKAY); drain();
        set_vd4(32'hB2, 32'hB3, 32'hB0, 32'hB1);
        read_burst(4'h2, 32'h00, 4'd3, INCR, 16'h0);
        set_vd4(32'hB0, 32'hB1, 32'hB2, 32'hB3);
        read_burst(4'h3, 32'h08, 4'd3, WRAP, 16'h0);

        // WLAST missing on final beat, then WLAST early
        vd[0] = 32'hC0; vd[1] = 32'hC1;
        write_burst(4'h2, 32'h20, 4'd1, INCR, 4'hF, 16'h0000, SLVERR); drain();
        read_burst(4'h2, 32'h20, 4'd1, INCR, 16'h0);
        vd[0] = 32'hF0; vd[1] = 32'hF1; vd[2] = 32'hF2;
        write_burst(4'h7, 32'h30, 4'd2, INCR, 4'hF, 16'h0005, SLVERR); drain();
        read_burst(4'h7, 32'h30, 4'd2, INCR, 16'h0);

        // Out-of-range write with BREADY stalled; word 0 must keep 0xB2
        vd[0] = 32'hDEADBEEF;
        bus.S_BREADY = 1'b0;
        write_burst(4'h4, 32'h400, 4'd0, INCR, 4'hF, 16'h0001, SLVERR);
        repeat (4) @(posedge clk);
        #1; bus.S_BREADY = 1'b1;
        drain();
        vd[0] = 32'hB2;
        read_burst(4'h4, 32'h00, 4'd0, INCR, 16'h0);
        vd[0] = 32'h11223344;
        write_burst(4'h5, 32'h3FC, 4'd0, INCR, 4'hF, 16'h0001, OKAY); drain();
        vd[0] = 32'h11223344; vd[1] = 32'h0;
        read_burst(4'h5, 32'h3FC, 4'd1, INCR, 16'h0002);

        // Byte strobes
        vd[0] = 32'hFFFFFFFF;
        write_burst(4'h6, 32'h40, 4'd0, INCR, 4'hF, 16'h0001, OKAY); drain();
        vd[0] = 32'h12345678;
        write_burst(4'h6, 32'h40, 4'd0, INCR, 4'h5, 16'h0001, OKAY); drain();
        vd[0] = 32'hFF34FF78;
        read_burst(4'h6, 32'h40, 4'd0, INCR, 16'h0);

        // Reserved burst type behaves as INCR with SLVERR everywhere
        vd[0] = 32'hD0; vd[1] = 32'hD1;
        write_burst(4'h8, 32'h50, 4'd1, RSVD, 4'hF, 16'h0002, SLVERR); drain();
        read_burst(4'h9, 32'h50, 4'd1, RSVD, 16'h0003);
        read_burst(4'h9, 32'h50, 4'd1, INCR, 16'h0);

        // FIXED burst hits one word
        vd[0] = 32'hE0; vd[1] = 32'hE1; vd[2] = 32'hE2;
        write_burst(4'hA, 32'h60, 4'd2, FIXED, 4'hF, 16'h0004, OKAY); drain();
        vd[0] = 32'hE2; vd[1] = 32'hE2;
        read_burst(4'hB, 32'h60, 4'd1, FIXED, 16'h0);

        // RREADY low for 5 cycles on a len-2 read
        set_vd4(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        push_r(4'hC, 4'd2, 16'h0);
        bus.S_RREADY = 1'b0;
        do_ar(4'hC, 32'h10, 4'd2, INCR);
        repeat (5) @(posedge clk);
        #1; bus.S_RREADY = 1'b1;
        drain();

        // Reset during beat 1 of a len-3 read
        push_r(4'hD, 4'd3, 16'h0);
        target = r_hs_cnt + 1;
        do_ar(4'hD, 32'h10, 4'd3, INCR);
        t = 0;
        while (r_hs_cnt < target && t < 50) begin @(posedge clk); #1; t++; end
        if (r_hs_cnt < target) timeout_fail("beat0_timeout");
        rst_n = 1'b0;
        #1;
        chk("midrst_rvalid",  {31'd0, bus.S_RVALID},  32'd0);
        chk("midrst_rlast",   {31'd0, bus.S_RLAST},   32'd0);
        chk("midrst_arready", {31'd0, bus.S_ARREADY}, 32'd0);
        chk("midrst_rdata",   bus.S_RDATA,            32'd0);
        r_q.delete();
        b_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arready_after_midrst", {31'd0, bus.S_ARREADY}, 32'd1);
        chk("awready_after_midrst", {31'd0, bus.S_AWREADY}, 32'd1);
        read_burst(4'hE, 32'h10, 4'd3, INCR, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
